seq_pattern_gen: RTL and testbench
==================================

Name: seq_pattern_gen

Overview:
Serial bit-pattern generator: the transmit end of the serial sequence-detection path.
- Accepts a pattern word and a length, repeat count and inter-repetition gap through a valid/ready handshake.
- Emits the pattern MSB-first, one bit per clock, on a single-bit serial output.
- Drives sequence-detector inputs in system test and self-check; marks frame starts and signals completion.

Parameters:
MAX_LEN, 16, maximum pattern length in bits (>=2).
CNT_W, 8, width of the repeat counter.
GAP_W, 4, width of the inter-repetition gap field.
LEN_W, $clog2(MAX_LEN+1), derived; width of the length field.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  reset, synchronous, active-high.
start_valid  input  1  request to start a transmission.
start_ready  output  1  block can accept a request; high only in IDLE.
pattern  input  MAX_LEN  bits to send; bit length-1 goes first, bit 0 goes last.
length  input  LEN_W  number of pattern bits; values above MAX_LEN clamp to MAX_LEN.
repeat_cnt  input  CNT_W  number of repetitions; 0 means send nothing.
gap  input  GAP_W  idle cycles between repetitions; none after the last one.
abort  input  1  synchronous cancel of the transmission in progress.
o  output  1  serial data bit; 0 whenever o_valid=0.
o_valid  output  1  o carries a pattern bit this cycle.
sof  output  1  high with the first bit of every repetition.
busy  output  1  high in SEND, GAP or DONE.
done  output  1  one-cycle pulse when all repetitions complete.

Behaviour:
- All outputs are registered. Reset values: o=0, o_valid=0, sof=0, done=0, busy=0, start_ready=1; state=IDLE.
- Reset has priority over every input, including during SEND or GAP.
- States: IDLE, SEND, GAP, DONE.
- Handshake: a request is accepted in cycle T when start_valid=1 and start_ready=1.
  - pattern, length (after clamp), repeat_cnt and gap are captured at T.
  - Later changes to the inputs have no effect on the transmission.
- IDLE:
  - Accept with effective length=0 or repeat_cnt=0 -> DONE. No bits are sent; done pulses at T+1.
  - Otherwise -> SEND. First bit on o with o_valid=1 and sof=1 at T+1.
- SEND: one bit per cycle, bit index counting from length-1 down to 0.
  - After bit 0, if repetitions remain and gap>0 -> GAP.
  - If repetitions remain and gap=0 -> the next repetition starts the very next cycle, with sof=1.
  - If no repetitions remain -> DONE.
- GAP: exactly gap cycles with o_valid=0 and o=0, then SEND with sof=1.
- DONE: done=1 for exactly one cycle, busy=1, start_ready=0; then -> IDLE.
- Timing: a new request can be accepted at the earliest in the cycle after DONE, i.e. the first IDLE cycle.
- Abort:
  - abort=1 in SEND, GAP or DONE -> IDLE on the next edge.
  - o_valid, sof and done are 0 from that edge; done never fires for an aborted transmission.
  - abort is ignored in IDLE and does not block acceptance.
- Counters:
  - Bit index is LEN_W wide and the repetition counter is CNT_W wide; neither wraps.
  - The repetition counter decrements at the end of each repetition; repeat_cnt = 2^CNT_W-1 is valid.
- Total o_valid cycles per transmission = length*repeat_cnt.
- Total busy cycles = length*repeat_cnt + gap*(repeat_cnt-1) + 1.

Test Plan:
- Single burst: pattern=0x000B, length=4, repeat=1, gap=0, accepted at T -> o=1,0,1,1 at T+1..T+4; sof only at T+1; done at T+5; start_ready=1 at T+6.
- Repeat with gap: pattern=0x000B, length=4, repeat=3, gap=2 -> bits at T+1..4, T+7..10, T+13..16 (o_valid=0, o=0 at T+5..6 and T+11..12); sof at T+1, T+7, T+13; done at T+17.
- Back-to-back gap=0: pattern=0x0006, length=3, repeat=2 -> o=1,1,0,1,1,0 at T+1..T+6; sof at T+1 and T+4; start_valid held high is next accepted at T+8.
- Degenerate requests:
  - length=0 -> done at T+1 with no o_valid cycles.
  - length=20 with MAX_LEN=16 -> exactly 16 bits sent, starting from pattern[15].
- Abort: assert abort during the 2nd bit of a length=8 burst -> o_valid=0 from the next cycle; done never pulses; start_ready=1 the cycle after abort.
- Reset mid-GAP: rst=1 for one cycle during GAP -> all outputs at reset values on the next edge; a new request is accepted normally afterwards.

Source files
------------

// File: rtl/seq_pattern_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_gen_if
// Brief    : Request handshake and serial output bundle of seq_pattern_gen.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_pattern_gen_if #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8,
    parameter int GAP_W   = 4,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
    logic               start_valid;
    logic               start_ready;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   length;
    logic [CNT_W-1:0]   repeat_cnt;
    logic [GAP_W-1:0]   gap;
    logic               abort;
    logic               o;
    logic               o_valid;
    logic               sof;
    logic               busy;
    logic               done;

    modport master (
        output start_valid, pattern, length, repeat_cnt, gap, abort,
        input  start_ready, o, o_valid, sof, busy, done
    );

    modport slave (
        input  start_valid, pattern, length, repeat_cnt, gap, abort,
        output start_ready, o, o_valid, sof, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_gen
// Brief    : Serial MSB-first bit-pattern generator with repeat count and gap.
// Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_gen #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8,
    parameter int GAP_W   = 4,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  wire logic        clk,
    input  wire logic        rst,
    seq_pattern_gen_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] c_max_len  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] c_len_one  = LEN_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [GAP_W-1:0] c_gap_one  = GAP_W'(1);

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [LEN_W-1:0]   bit_q, bit_d;
    logic [CNT_W-1:0]   rep_q, rep_d;
    logic [GAP_W-1:0]   gcnt_q, gcnt_d;
    logic               o_q, o_d;
    logic               valid_q, valid_d;
    logic               sof_q, sof_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;

    logic [LEN_W-1:0]   w_len_eff;
    logic [LEN_W-1:0]   w_len_in_m1;
    logic [LEN_W-1:0]   w_len_q_m1;
    logic [LEN_W-1:0]   w_bit_m1;
    logic [MAX_LEN-1:0] w_in_shift;
    logic [MAX_LEN-1:0] w_first_shift;
    logic [MAX_LEN-1:0] w_next_shift;

    assign w_len_eff     = (bus.length > c_max_len) ? c_max_len : bus.length;
    assign w_len_in_m1   = w_len_eff - c_len_one;
    assign w_len_q_m1    = len_q - c_len_one;
    assign w_bit_m1      = bit_q - c_len_one;
    // Shifts instead of variable bit-selects keep the index width independent of MAX_LEN.
    assign w_in_shift    = bus.pattern >> w_len_in_m1;
    assign w_first_shift = pat_q >> w_len_q_m1;
    assign w_next_shift  = pat_q >> w_bit_m1;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        gap_d   = gap_q;
        bit_d   = bit_q;
        rep_d   = rep_q;
        gcnt_d  = gcnt_q;
        o_d     = 1'b0;
        valid_d = 1'b0;
        sof_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        ready_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (bus.start_valid) begin
                    pat_d   = bus.pattern;
                    len_d   = w_len_eff;
                    gap_d   = bus.gap;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    if ((w_len_eff == '0) || (bus.repeat_cnt == '0)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SEND;
                        bit_d   = w_len_in_m1;
                        rep_d   = bus.repeat_cnt - c_cnt_one;
                        o_d     = w_in_shift[0];
                        valid_d = 1'b1;
                        sof_d   = 1'b1;
                    end
                end
            end

            S_SEND: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end else if (bit_q != '0) begin
                    bit_d   = w_bit_m1;
                    o_d     = w_next_shift[0];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (rep_q != '0) begin
                    // rep_q counts repetitions still owed after the current one
                    rep_d  = rep_q - c_cnt_one;
                    busy_d = 1'b1;
                    if (gap_q != '0) begin
                        state_d = S_GAP;
                        gcnt_d  = gap_q;
                    end else begin
                        bit_d   = w_len_q_m1;
                        o_d     = w_first_shift[0];
                        valid_d = 1'b1;
                        sof_d   = 1'b1;
                    end
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end

            S_GAP: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end else if (gcnt_q <= c_gap_one) begin
                    state_d = S_SEND;
                    bit_d   = w_len_q_m1;
                    o_d     = w_first_shift[0];
                    valid_d = 1'b1;
                    sof_d   = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    gcnt_d = gcnt_q - c_gap_one;
                    busy_d = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            bit_q   <= '0;
            rep_q   <= '0;
            gcnt_q  <= '0;
            o_q     <= 1'b0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            bit_q   <= bit_d;
            rep_q   <= rep_d;
            gcnt_q  <= gcnt_d;
            o_q     <= o_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign bus.o           = o_q;
    assign bus.o_valid     = valid_q;
    assign bus.sof         = sof_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.start_ready = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_pattern_gen
// Brief    : Self-checking bench for seq_pattern_gen against a per-cycle queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_gen;
    localparam int MAX_LEN = 16;
    localparam int CNT_W   = 8;
    localparam int GAP_W   = 4;
    localparam int LEN_W   = 5;

    // Output vector layout: {o, o_valid, sof, busy, done, start_ready}
    localparam logic [5:0] c_idle = 6'b000001;
    localparam logic [5:0] c_gap  = 6'b000100;
    localparam logic [5:0] c_done = 6'b000110;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_pattern_gen_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .GAP_W(GAP_W), .LEN_W(LEN_W)) bus ();

    seq_pattern_gen #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .GAP_W(GAP_W), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [5:0]  exp_cur = c_idle;
    logic [5:0]  exp_nxt;
    logic [5:0]  q[$];
    int          acc_cyc  = -1;
    int          acc_prev = -1;
    int          n_acc    = 0;
    logic [63:0] bits;
    int          nbits;
    logic [63:0] sof_mask;
    int          done_off;
    int          busy_cnt;

    task automatic check_eq(input string name, input longint got, input longint want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Expected per-cycle output stream of one accepted request.
    task automatic build(input logic [15:0] p, input int len, input int rep, input int g);
        int eff;
        eff = (len > MAX_LEN) ? MAX_LEN : len;
        q.delete();
        if (eff != 0 && rep != 0) begin
            for (int r = 0; r < rep; r++) begin
                for (int i = 0; i < eff; i++)
                    q.push_back({p[eff-1-i], 1'b1, (i == 0), 1'b1, 1'b0, 1'b0});
                if (r < rep - 1)
                    for (int k = 0; k < g; k++) q.push_back(c_gap);
            end
        end
        q.push_back(c_done);
    endtask

    task automatic model_update();
        if (rst === 1'b1) begin
            q.delete();
            exp_nxt = c_idle;
        end else if (exp_cur[0] && bus.start_valid) begin
            build(bus.pattern, int'(bus.length), int'(bus.repeat_cnt), int'(bus.gap));
            acc_prev = acc_cyc;
            acc_cyc  = cyc;
            n_acc++;
            bits = '0; nbits = 0; sof_mask = '0; done_off = -1; busy_cnt = 0;
            exp_nxt = q.pop_front();
        end else if (exp_cur[2] && bus.abort) begin
            q.delete();
            exp_nxt = c_idle;
        end else begin
            exp_nxt = (q.size() != 0) ? q.pop_front() : c_idle;
        end
    endtask

    task automatic tick();
        logic [5:0] got;
        int off;
        model_update();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        exp_cur = exp_nxt;
        got = {bus.o, bus.o_valid, bus.sof, bus.busy, bus.done, bus.start_ready};
        n_tests++;
        if (got !== exp_cur) begin
            n_fail++;
            $display("FAIL cycle_out @%0d: got {o,v,sof,busy,done,rdy}=%b, expected %b", cyc, got, exp_cur);
        end
        off = cyc - acc_cyc;
        if (bus.o_valid === 1'b1) begin
            bits = {bits[62:0], bus.o};
            nbits++;
        end
        if (bus.sof === 1'b1 && off >= 0 && off < 64) sof_mask[off] = 1'b1;
        if (bus.done === 1'b1) done_off = off;
        if (bus.busy === 1'b1) busy_cnt++;
    endtask

    task automatic scramble();
        bus.pattern    = 16'($urandom);
        bus.length     = 5'($urandom_range(0, 20));
        bus.repeat_cnt = 8'($urandom_range(0, 3));
        bus.gap        = 4'($urandom_range(0, 3));
    endtask

    task automatic req(input logic [15:0] p, input int len, input int rep, input int g);
        bus.start_valid = 1'b1;
        bus.pattern     = p;
        bus.length      = 5'(len);
        bus.repeat_cnt  = 8'(rep);
        bus.gap         = 4'(g);
        tick();
        bus.start_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (!(exp_cur == c_idle && q.size() == 0) && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle: timeout after %0d cycles, expected return to idle", budget);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int start_acc;
        bus.start_valid = 1'b0;
        bus.abort       = 1'b0;
        bus.pattern     = '0;
        bus.length      = '0;
        bus.repeat_cnt  = '0;
        bus.gap         = '0;
        rst = 1'b1;
        @(negedge clk);
        tick();
        tick();
        check_eq("reset_ready", longint'(bus.start_ready), 1);
        rst = 1'b0;
        tick();

        // Single burst
        req(16'h000B, 4, 1, 0);
        wait_idle(50);
        check_eq("burst_bits", longint'(bits[3:0]), 4'b1011);
        check_eq("burst_nbits", nbits, 4);
        check_eq("burst_sof", longint'(sof_mask), 64'h2);
        check_eq("burst_done", done_off, 5);

        // Repeat with gap
        req(16'h000B, 4, 3, 2);
        wait_idle(100);
        check_eq("gap_bits", longint'(bits[11:0]), 12'hBBB);
        check_eq("gap_nbits", nbits, 12);
        check_eq("gap_sof", longint'(sof_mask), 64'h2082);
        check_eq("gap_done", done_off, 17);
        check_eq("gap_busy", busy_cnt, 17);

        // Back-to-back, start_valid held
        start_acc = n_acc;
        bus.start_valid = 1'b1;
        bus.pattern = 16'h0006; bus.length = 5'd3; bus.repeat_cnt = 8'd2; bus.gap = 4'd0;
        for (int k = 0; k < 30 && n_acc < start_acc + 2; k++) tick();
        bus.start_valid = 1'b0;
        check_eq("b2b_accept_gap", acc_cyc - acc_prev, 8);
        wait_idle(50);
        check_eq("b2b_bits", longint'(bits[5:0]), 6'b110110);
        check_eq("b2b_sof", longint'(sof_mask), 64'h12);

        // Degenerate requests
        req(16'hFFFF, 0, 3, 1);
        wait_idle(20);
        check_eq("len0_done", done_off, 1);
        check_eq("len0_nbits", nbits, 0);
        req(16'hA5C3, 20, 1, 0);
        wait_idle(50);
        check_eq("clamp_nbits", nbits, 16);
        check_eq("clamp_bits", longint'(bits[15:0]), 16'hA5C3);
        req(16'h00FF, 5, 0, 2);
        wait_idle(20);
        check_eq("rep0_done", done_off, 1);

        // Maximum repeat count
        req(16'h0002, 2, 255, 0);
        wait_idle(1000);
        check_eq("rep255_nbits", nbits, 510);
        check_eq("rep255_done", done_off, 511);

        // Abort during the second bit
        req(16'h00A5, 8, 1, 0);
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check_eq("abort_nbits", nbits, 2);
        check_eq("abort_no_done", done_off, -1);

        // Reset during GAP
        req(16'h0005, 3, 3, 4);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rstgap_busy", longint'(bus.busy), 0);
        check_eq("rstgap_nbits", nbits, 3);
        req(16'h0005, 3, 1, 0);
        wait_idle(20);
        check_eq("rstgap_after_bits", longint'(bits[2:0]), 3'b101);

        // Random traffic, inputs changing every cycle
        for (int k = 0; k < 4000; k++) begin
            bus.start_valid = ($urandom_range(0, 2) == 0);
            bus.abort       = ($urandom_range(0, 29) == 0);
            rst             = ($urandom_range(0, 299) == 0);
            scramble();
            if ($urandom_range(0, 9) == 0) bus.gap = 4'd15;
            tick();
        end
        rst = 1'b0;
        bus.start_valid = 1'b0;
        bus.abort = 1'b0;
        wait_idle(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
